// File: rtl/tcdm_bank_arbiter_if.sv
// tcdm_bank_arbiter_if: requester-side bus and bank-side bus of one TCDM bank front end
// req/add/wen/be/data : packed per-requester request fields, requester k at slice k
// gnt/r_valid/r_data  : one-hot grant, one-hot response valid, broadcast read data
// bank_*              : single-ported bank interface, bank_r_data valid the cycle after a read
interface tcdm_bank_arbiter_if #(
  parameter int NB_REQ = 4,
  parameter int BANK_SIZE = 256,
  parameter int DATA_WIDTH = 32
);
  localparam int AW = $clog2(BANK_SIZE);
  localparam int BW = DATA_WIDTH / 8;
  logic [NB_REQ-1:0] req;
  logic [NB_REQ*AW-1:0] add;
  logic [NB_REQ-1:0] wen;
  logic [NB_REQ*BW-1:0] be;
  logic [NB_REQ*DATA_WIDTH-1:0] data;
  logic [NB_REQ-1:0] gnt;
  logic [NB_REQ-1:0] r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic bank_req;
  logic [AW-1:0] bank_add;
  logic bank_wen;
  logic [BW-1:0] bank_be;
  logic [DATA_WIDTH-1:0] bank_data;
  logic [DATA_WIDTH-1:0] bank_r_data;
  modport slave (
    input req, add, wen, be, data, bank_r_data,
    output gnt, r_valid, r_data, bank_req, bank_add, bank_wen, bank_be, bank_data
  );
  modport master (
    output req, add, wen, be, data, bank_r_data,
    input gnt, r_valid, r_data, bank_req, bank_add, bank_wen, bank_be, bank_data
  );
endinterface

// File: rtl/tcdm_bank_arbiter.sv
// tcdm_bank_arbiter: round-robin sharing of one TCDM bank among NB_REQ requesters, with zero-fill sequencer
// clk_i, rst_ni : clock, asynchronous active-low reset
// init_req_i    : pulse to start a zero-fill (ignored while one is running)
// init_busy_o   : high during zero-fill; init_done_o pulses in the first cycle after it
// bus           : requester and bank signals (slave modport)
module tcdm_bank_arbiter #(
  parameter int NB_REQ = 4,
  parameter int BANK_SIZE = 256,
  parameter int DATA_WIDTH = 32,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic init_req_i,
  output logic init_busy_o,
  output logic init_done_o,
  tcdm_bank_arbiter_if.slave bus
);
  localparam int AW = $clog2(BANK_SIZE);
  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NB_REQ);
  typedef enum logic {RUN, INIT} state_t;
  state_t state, next;
  logic [AW-1:0] cnt;
  logic [IW-1:0] rr_ptr, win, idx;
  logic hit, last, init;
  assign init = state == INIT;
  assign last = cnt == AW'(BANK_SIZE - 1);
  assign init_busy_o = init;
  assign bus.r_data = bus.bank_r_data;
  // descending scan so the requester closest to rr_ptr is the last one written
  always_comb begin
    win = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % NB_REQ);
      if (bus.req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= INIT_ON_RESET ? INIT : RUN;
    else state <= next;
  always_comb next = init ? (last ? RUN : INIT) : (init_req_i ? INIT : RUN);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt <= '0;
      rr_ptr <= '0;
      bus.r_valid <= '0;
      init_done_o <= 1'b0;
    end else begin
      bus.r_valid <= bus.gnt;
      init_done_o <= init && last;
      if (init) cnt <= last ? '0 : cnt + 1'b1;
      if (!init && hit) rr_ptr <= (win == IW'(NB_REQ - 1)) ? '0 : win + 1'b1;
    end
  always_comb begin
    bus.gnt = (!init && hit) ? NB_REQ'(1) << win : '0;
    bus.bank_req = init || hit;
    bus.bank_add = init ? cnt : bus.add[win*AW +: AW];
    bus.bank_wen = init ? 1'b0 : bus.wen[win];
    bus.bank_be = init ? '1 : bus.be[win*BW +: BW];
    bus.bank_data = init ? '0 : bus.data[win*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// tb_tcdm_bank_arbiter: randomized and directed check of tcdm_bank_arbiter against a behavioural model
module tb_tcdm_bank_arbiter;
  localparam int N = 4, BS = 256, DW = 32, AW = 8, BW = 4;
  logic clk = 0, rst_n = 1, init_req = 0;
  logic init_busy, init_done;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  tcdm_bank_arbiter_if #(.NB_REQ(N), .BANK_SIZE(BS), .DATA_WIDTH(DW)) bus();
  tcdm_bank_arbiter #(.NB_REQ(N), .BANK_SIZE(BS), .DATA_WIDTH(DW), .INIT_ON_RESET(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req),
    .init_busy_o(init_busy), .init_done_o(init_done), .bus(bus)
  );
  logic [DW-1:0] mem [BS];
  logic [DW-1:0] rdata;
  assign bus.bank_r_data = rdata;
  always @(posedge clk)
    if (bus.bank_req) begin
      if (bus.bank_wen) rdata <= mem[bus.bank_add];
      else for (int b = 0; b < BW; b++) if (bus.bank_be[b]) mem[bus.bank_add][8*b +: 8] <= bus.bank_data[8*b +: 8];
    end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  bit m_init = 1;
  int m_cnt = 0, m_ptr = 0;
  logic [N-1:0] m_rv = 0;
  logic m_done = 0, m_rd = 0;
  logic [DW-1:0] m_rdata = 0;
  logic [DW-1:0] shadow [BS];
  function automatic int winner(logic [N-1:0] r, int p, bit busy);
    if (busy) return -1;
    for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction
  always @(negedge clk) begin : cmp
    int k;
    k = winner(bus.req, m_ptr, m_init);
    chk("gnt", bus.gnt, k >= 0 ? N'(1) << k : N'(0));
    chk("bank_req", bus.bank_req, m_init || k >= 0);
    if (m_init) begin
      chk("init_add", bus.bank_add, m_cnt);
      chk("init_wen", bus.bank_wen, 0);
      chk("init_be", bus.bank_be, 4'hF);
      chk("init_data", bus.bank_data, 0);
    end else if (k >= 0) begin
      chk("bank_add", bus.bank_add, bus.add[k*AW +: AW]);
      chk("bank_wen", bus.bank_wen, bus.wen[k]);
      chk("bank_be", bus.bank_be, bus.be[k*BW +: BW]);
      chk("bank_data", bus.bank_data, bus.data[k*DW +: DW]);
    end
    chk("r_valid", bus.r_valid, m_rv);
    chk("init_busy", init_busy, m_init);
    chk("init_done", init_done, m_done);
    if (m_rd) chk("r_data", bus.r_data, m_rdata);
  end
  always @(posedge clk or negedge rst_n) begin : mdl
    int k, a;
    if (!rst_n) begin
      m_init = 1; m_cnt = 0; m_ptr = 0; m_rv = 0; m_done = 0; m_rd = 0;
    end else begin
      k = winner(bus.req, m_ptr, m_init);
      m_rv = k >= 0 ? N'(1) << k : N'(0);
      m_rd = k >= 0 && bus.wen[k];
      m_done = 0;
      if (k >= 0) begin
        a = int'(bus.add[k*AW +: AW]);
        if (bus.wen[k]) m_rdata = shadow[a];
        else for (int b = 0; b < BW; b++) if (bus.be[k*BW + b]) shadow[a][8*b +: 8] = bus.data[k*DW + 8*b +: 8];
        m_ptr = (k + 1) % N;
      end
      if (m_init) begin
        shadow[m_cnt] = 0;
        if (m_cnt == BS - 1) begin m_init = 0; m_cnt = 0; m_done = 1; end
        else m_cnt++;
      end else if (init_req) m_init = 1;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(int k, bit w, int a, logic [BW-1:0] b, logic [DW-1:0] d);
    bus.wen[k] = w;
    bus.add[k*AW +: AW] = AW'(a);
    bus.be[k*BW +: BW] = b;
    bus.data[k*DW +: DW] = d;
  endtask
  int n;
  initial begin
    for (int i = 0; i < BS; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    bus.req = 0; bus.add = 0; bus.wen = 0; bus.be = 0; bus.data = 0;
    #1 rst_n = 0;
    #1 chk("rst_busy", init_busy, 1);
    chk("rst_rvalid", bus.r_valid, 0);
    step(); step();
    bus.req = 4'b1111;
    for (int k = 0; k < N; k++) set_req(k, 1, k, 4'hF, 0);
    rst_n = 1;
    n = 0;
    while (init_busy && n < 1000) begin step(); n++; end
    chk("init_len", n, 256);
    chk("done_pulse", init_done, 1);
    for (int i = 0; i < 5; i++) begin
      chk("rr_gnt", bus.gnt, 4'b0001 << (i % 4));
      if (i > 0) chk("rr_rvalid", bus.r_valid, 4'b0001 << ((i - 1) % 4));
      step();
    end
    bus.req = 4'b0100;
    set_req(2, 0, 5, 4'b0011, 32'hDEADBEEF);
    #1 chk("wr_gnt", bus.gnt, 4'b0100);
    step();
    set_req(2, 1, 5, 4'hF, 0);
    #1 chk("rd_gnt", bus.gnt, 4'b0100);
    chk("wr_rvalid", bus.r_valid, 4'b0100);
    step();
    chk("rd_rvalid", bus.r_valid, 4'b0100);
    chk("rd_data", bus.r_data, 32'h0000BEEF);
    bus.req = 4'b0101;
    #1 chk("wrap0", bus.gnt, 4'b0001);
    step();
    chk("wrap1", bus.gnt, 4'b0100);
    step();
    chk("wrap2", bus.gnt, 4'b0001);
    step();
    bus.req = 4'b1111;
    init_req = 1;
    #1 chk("ireq_gnt", bus.gnt, 4'b0010);
    step();
    init_req = 0;
    #1 chk("ireq_rvalid", bus.r_valid, 4'b0010);
    chk("ireq_hold", bus.gnt, 0);
    n = 0;
    while (init_busy && n < 1000) begin init_req = (n == 10); n++; step(); end
    init_req = 0;
    #1 chk("reinit_len", n, 256);
    chk("reinit_done", init_done, 1);
    chk("ptr_kept", bus.gnt, 4'b0100);
    for (int i = 0; i < 3000; i++) begin
      bus.req = N'($urandom);
      for (int k = 0; k < N; k++) set_req(k, 1'($urandom), $urandom_range(0, 15), BW'($urandom), $urandom);
      init_req = $urandom_range(0, 299) == 0;
      step();
    end
    init_req = 0;
    bus.req = 0;
    n = 0;
    while (init_busy && n < 1000) begin step(); n++; end
    chk("run_before_rst", init_busy, 0);
    init_req = 1;
    step();
    init_req = 0;
    bus.req = 4'b1111;
    repeat (100) step();
    chk("init100_add", bus.bank_add, 100);
    rst_n = 0;
    #1 chk("arst_gnt", bus.gnt, 0);
    chk("arst_rvalid", bus.r_valid, 0);
    chk("arst_done", init_done, 0);
    chk("arst_busy", init_busy, 1);
    chk("arst_add", bus.bank_add, 0);
    step(); step();
    rst_n = 1;
    #1 chk("restart_add0", bus.bank_add, 0);
    n = 0;
    while (init_busy && n < 1000) begin
      step();
      n++;
      if (n == 1) chk("restart_add1", bus.bank_add, 1);
    end
    chk("restart_len", n, 256);
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
